// File: rtl/bufmgr_selctrl.sv
// Ring-ordered packet buffer manager shared by sniffer, CPU and forwarder.
// Tracks each buffer's lifecycle and drives agent selects plus inverted per-buffer selects.
module bufmgr_selctrl #(
  parameter int N_BUF = 3,
  parameter int CNT_W = 16,
  localparam int SELW = $clog2(N_BUF + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sn_req,
  input  logic                 sn_done,
  input  logic                 cpu_req,
  input  logic                 cpu_done,
  input  logic                 cpu_accept,
  input  logic                 fwd_req,
  input  logic                 fwd_done,
  output logic [SELW-1:0]      sn_sel,
  output logic [SELW-1:0]      cpu_sel,
  output logic [SELW-1:0]      fwd_sel,
  output logic [2*N_BUF-1:0]   buf_sel,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int PW = (N_BUF > 1) ? $clog2(N_BUF) : 1;

  localparam logic [SELW-1:0]  SEL_NONE = {SELW{1'b0}};
  localparam logic [SELW-1:0]  SEL_ONE  = {{(SELW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PTR_LAST = PW'(N_BUF - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_FREE = 3'd0,
    ST_FILL = 3'd1,
    ST_FULL = 3'd2,
    ST_FILT = 3'd3,
    ST_PASS = 3'd4,
    ST_SEND = 3'd5,
    ST_DROP = 3'd6
  } buf_state_e;

  buf_state_e      state_r [N_BUF];
  logic [PW-1:0]   sn_ptr_r;
  logic [PW-1:0]   cpu_ptr_r;
  logic [PW-1:0]   fwd_ptr_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  function automatic logic [SELW-1:0] ptr_to_sel(input logic [PW-1:0] p);
    ptr_to_sel = SELW'(p) + SEL_ONE;
  endfunction

  // Buffer lifecycle, ring pointers, agent selects and verdict counters.
  // An agent only ever touches the buffer at its own pointer, and the state guards keep
  // those buffers disjoint within a cycle, so the three agent branches never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BUF; i++) begin
        state_r[i] <= ST_FREE;
      end
      sn_ptr_r  <= PTR_ZERO;
      cpu_ptr_r <= PTR_ZERO;
      fwd_ptr_r <= PTR_ZERO;
      sn_sel    <= SEL_NONE;
      cpu_sel   <= SEL_NONE;
      fwd_sel   <= SEL_NONE;
      pass_cnt  <= CNT_ZERO;
      drop_cnt  <= CNT_ZERO;
    end else begin
      if (sn_sel != SEL_NONE) begin
        if (sn_done) begin
          state_r[sn_ptr_r] <= ST_FULL;
          sn_sel            <= SEL_NONE;
          sn_ptr_r          <= ptr_inc(sn_ptr_r);
        end
      end else if (sn_req && (state_r[sn_ptr_r] == ST_FREE)) begin
        state_r[sn_ptr_r] <= ST_FILL;
        sn_sel            <= ptr_to_sel(sn_ptr_r);
      end

      if (cpu_sel != SEL_NONE) begin
        if (cpu_done) begin
          cpu_sel   <= SEL_NONE;
          cpu_ptr_r <= ptr_inc(cpu_ptr_r);
          if (cpu_accept) begin
            state_r[cpu_ptr_r] <= ST_PASS;
            pass_cnt           <= pass_cnt + CNT_ONE;
          end else begin
            state_r[cpu_ptr_r] <= ST_DROP;
            drop_cnt           <= drop_cnt + CNT_ONE;
          end
        end
      end else if (cpu_req && (state_r[cpu_ptr_r] == ST_FULL)) begin
        state_r[cpu_ptr_r] <= ST_FILT;
        cpu_sel            <= ptr_to_sel(cpu_ptr_r);
      end

      // Rejected buffers are reclaimed by the forwarder's pointer so ring order holds.
      if (fwd_sel != SEL_NONE) begin
        if (fwd_done) begin
          state_r[fwd_ptr_r] <= ST_FREE;
          fwd_sel            <= SEL_NONE;
          fwd_ptr_r          <= ptr_inc(fwd_ptr_r);
        end
      end else if (state_r[fwd_ptr_r] == ST_DROP) begin
        state_r[fwd_ptr_r] <= ST_FREE;
        fwd_ptr_r          <= ptr_inc(fwd_ptr_r);
      end else if (fwd_req && (state_r[fwd_ptr_r] == ST_PASS)) begin
        state_r[fwd_ptr_r] <= ST_SEND;
        fwd_sel            <= ptr_to_sel(fwd_ptr_r);
      end
    end
  end

  // Per-buffer owner code, inverted from the registered agent selects.
  always_comb begin
    buf_sel = {(2*N_BUF){1'b0}};
    for (int i = 0; i < N_BUF; i++) begin
      if (sn_sel == SELW'(i + 1)) begin
        buf_sel[2*i +: 2] = 2'b01;
      end else if (cpu_sel == SELW'(i + 1)) begin
        buf_sel[2*i +: 2] = 2'b10;
      end else if (fwd_sel == SELW'(i + 1)) begin
        buf_sel[2*i +: 2] = 2'b11;
      end else begin
        buf_sel[2*i +: 2] = 2'b00;
      end
    end
  end

endmodule
